vid_mask_gen: RTL

Synthetic video-stream source: drives the de/hsync/vsync/mask interface consumed by the centroid block, with a rectangular skin-mask blob at a programmable position. Used as the stimulus end of the skin_color_segm pipeline for bring-up and self-test. It also reports the exact mask pixel count per frame so downstream moment/centroid results can be checked in-system.

---
 rtl/vid_mask_gen.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vid_mask_gen.sv
`default_nettype none
// ============================================================================
// Module   : vid_mask_gen
// Purpose  : Synthetic de/hsync/vsync video source with a rectangular mask
//            blob and an exact per-frame mask pixel count.
// Revision : 1.0 - initial release
// ============================================================================
module vid_mask_gen #(
    parameter int IMG_W   = 720,
    parameter int IMG_H   = 576,
    parameter int H_BLANK = 144,
    parameter int H_SYNC  = 64,
    parameter int V_BLANK = 49
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        enable,
    input  logic [9:0]  rect_x0,
    input  logic [9:0]  rect_y0,
    input  logic [9:0]  rect_w,
    input  logic [9:0]  rect_h,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        mask,
    output logic        frame_done,
    output logic [18:0] mask_cnt,
    output logic        busy
);

    localparam logic [9:0] c_line_last = 10'(IMG_W + H_BLANK - 1);
    localparam logic [9:0] c_x_last    = 10'(IMG_W - 1);
    localparam logic [9:0] c_y_last    = 10'(IMG_H - 1);
    localparam logic [9:0] c_hb_last   = 10'(H_BLANK - 1);
    localparam logic [9:0] c_vb_last   = 10'(V_BLANK - 1);
    localparam logic [9:0] c_img_w     = 10'(IMG_W);
    localparam logic [9:0] c_hs_end    = 10'(IMG_W + H_SYNC);
    localparam logic [9:0] c_h_sync    = 10'(H_SYNC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VBLANK = 2'd1,
        S_ACTIVE = 2'd2,
        S_HBLANK = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_cnt;
    logic [9:0]  r_line;
    logic [9:0]  w_cnt_nxt;
    logic [9:0]  w_line_nxt;
    logic [9:0]  r_x0;
    logic [9:0]  r_y0;
    logic [9:0]  r_w;
    logic [9:0]  r_h;
    logic [18:0] r_acc;
    logic        w_latch;
    logic        w_frame_end;
    logic        w_de_nxt;
    logic        w_vsync_nxt;
    logic        w_hsync_nxt;
    logic        w_mask_nxt;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    // r_cnt is the column within the full line in VBLANK, the pixel column in
    // ACTIVE and the blank cycle in HBLANK; r_line is the blank line or y.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_line_nxt  = r_line;
        w_latch     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_VBLANK;
                    w_cnt_nxt   = '0;
                    w_line_nxt  = '0;
                    w_latch     = 1'b1;
                end
            end
            S_VBLANK: begin
                if (r_cnt == c_line_last) begin
                    w_cnt_nxt = '0;
                    if (r_line == c_vb_last) begin
                        w_state_nxt = S_ACTIVE;
                        w_line_nxt  = '0;
                    end else begin
                        w_line_nxt = r_line + 10'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            S_ACTIVE: begin
                if (r_cnt == c_x_last) begin
                    w_state_nxt = S_HBLANK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            default: begin
                if (r_cnt == c_hb_last) begin
                    w_cnt_nxt = '0;
                    if (r_line == c_y_last) begin
                        w_frame_end = 1'b1;
                        w_line_nxt  = '0;
                        if (enable) begin
                            w_state_nxt = S_VBLANK;
                            w_latch     = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_state_nxt = S_ACTIVE;
                        w_line_nxt  = r_line + 10'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_comb begin
        w_x_end     = {1'b0, r_x0} + {1'b0, r_w};
        w_y_end     = {1'b0, r_y0} + {1'b0, r_h};
        w_de_nxt    = (w_state_nxt == S_ACTIVE);
        w_vsync_nxt = (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_HBLANK);
        w_hsync_nxt = 1'b1;
        if (w_state_nxt == S_VBLANK) begin
            w_hsync_nxt = !((w_cnt_nxt >= c_img_w) && (w_cnt_nxt < c_hs_end));
        end else if (w_state_nxt == S_HBLANK) begin
            w_hsync_nxt = !(w_cnt_nxt < c_h_sync);
        end
        w_mask_nxt = w_de_nxt
                  && (w_cnt_nxt >= r_x0) && ({1'b0, w_cnt_nxt} < w_x_end)
                  && (w_line_nxt >= r_y0) && ({1'b0, w_line_nxt} < w_y_end);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_line     <= '0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_acc      <= '0;
            de         <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b0;
            mask       <= 1'b0;
            frame_done <= 1'b0;
            mask_cnt   <= '0;
            busy       <= 1'b0;
        end else if (ce) begin
            r_cnt      <= w_cnt_nxt;
            r_line     <= w_line_nxt;
            de         <= w_de_nxt;
            hsync      <= w_hsync_nxt;
            vsync      <= w_vsync_nxt;
            mask       <= w_mask_nxt;
            frame_done <= w_frame_end;
            busy       <= (w_state_nxt != S_IDLE);
            if (w_latch) begin
                r_x0 <= rect_x0;
                r_y0 <= rect_y0;
                r_w  <= rect_w;
                r_h  <= rect_h;
            end
            // The frame-end cycle always follows HBLANK, so mask is 0 there.
            if (w_frame_end) begin
                mask_cnt <= r_acc;
                r_acc    <= '0;
            end else if (mask) begin
                r_acc <= r_acc + 19'd1;
            end
        end
    end

endmodule
`default_nettype wire
